// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: FSM states, framing constants and the
// reflected CRC-32 byte update used by crc32_d8.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam int          ETH_MIN_PAYLOAD = 60;

  // One byte of the LSB-first CRC-32, unrolled into pure combinational logic.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 accumulator: combinational next state,
// registered state, synchronous clear and enable.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        eth_clk,
  input  logic        sys_rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/rmii_tx_mac.sv
// RMII transmit MAC: preamble/SFD, payload, optional zero pad (RMII_TX_PAD_EN),
// FCS and inter-frame gap, two bits per eth_clk, LSB dibit first.
module rmii_tx_mac
  import eth_pkg::*;
#(
  parameter int IFG_BYTES = 12
) (
  input  logic       eth_clk,
  input  logic       sys_rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       eth_txen,
  output logic [1:0] eth_tx,
  output logic       busy,
  output logic       err_underrun
);

  localparam int IFG_CLKS = IFG_BYTES * 4;

  tx_state_t   state;
  tx_state_t   nxt_state;
  logic [1:0]  dibit;
  logic [7:0]  tx_byte;
  logic [7:0]  nxt_byte;
  logic [2:0]  pre_cnt;
  logic [1:0]  fcs_idx;
  logic [1:0]  fcs_nxt_idx;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_inc;
  logic        last_byte;
  logic [15:0] ifg_cnt;
  logic        byte_end;
  logic        accept;
  logic        underrun;
  logic        fcs_done;
  logic        pad_load;
  logic        crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_val;
  logic [31:0] fcs_word;

  assign byte_end     = (dibit == 2'd3);
  assign s_ready      = byte_end && ((state == SFD) || ((state == DATA) && !last_byte));
  assign accept       = s_valid && s_ready;
  assign underrun     = s_ready && !s_valid;
  assign fcs_done     = (state == FCS) && (fcs_idx == 2'd3);
  assign busy         = (state != IDLE);
  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign fcs_word     = ~crc_val;
  assign fcs_nxt_idx  = fcs_idx + 2'd1;

`ifdef RMII_TX_PAD_EN
  assign pad_load = byte_end && (byte_cnt < 11'(ETH_MIN_PAYLOAD)) &&
                    (((state == DATA) && last_byte) || (state == PAD));
`else
  assign pad_load = 1'b0;
`endif

  assign crc_en   = accept || pad_load;
  assign crc_data = accept ? s_data : 8'h00;

  crc32_d8 u_crc (
    .eth_clk   (eth_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (state == IDLE),
    .en        (crc_en),
    .data      (crc_data),
    .crc       (crc_val)
  );

  // Byte and state that follow the current byte when it finishes.
  always_comb begin
    nxt_byte  = 8'h00;
    nxt_state = state;
    case (state)
      PREAMBLE: begin
        nxt_byte  = (pre_cnt == 3'd6) ? ETH_SFD : ETH_PREAMBLE;
        nxt_state = (pre_cnt == 3'd6) ? SFD : PREAMBLE;
      end
      SFD, DATA: begin
        if ((state == SFD) || !last_byte) begin
          nxt_byte  = s_data;
          nxt_state = DATA;
        end else if (pad_load) begin
          nxt_state = PAD;
        end else begin
          nxt_byte  = fcs_word[7:0];
          nxt_state = FCS;
        end
      end
      PAD: begin
        if (!pad_load) begin
          nxt_byte  = fcs_word[7:0];
          nxt_state = FCS;
        end
      end
      FCS:     nxt_byte = fcs_word[{fcs_nxt_idx, 3'b000} +: 8];
      default: ;
    endcase
  end

  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      dibit        <= 2'd0;
      tx_byte      <= 8'h00;
      pre_cnt      <= 3'd0;
      fcs_idx      <= 2'd0;
      byte_cnt     <= 11'd0;
      last_byte    <= 1'b0;
      ifg_cnt      <= 16'd0;
      eth_txen     <= 1'b0;
      eth_tx       <= 2'b00;
      err_underrun <= 1'b0;
    end else begin
      err_underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            state     <= PREAMBLE;
            pre_cnt   <= 3'd0;
            fcs_idx   <= 2'd0;
            byte_cnt  <= 11'd0;
            last_byte <= 1'b0;
            dibit     <= 2'd0;
            tx_byte   <= ETH_PREAMBLE;
            eth_txen  <= 1'b1;
            eth_tx    <= ETH_PREAMBLE[1:0];
          end
        end
        // One clock short: the IDLE sampling cycle completes the gap.
        IFG: begin
          if (ifg_cnt == 16'(IFG_CLKS - 2)) begin
            state <= IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + 16'd1;
          end
        end
        default: begin
          if (!byte_end) begin
            dibit  <= dibit + 2'd1;
            eth_tx <= tx_byte[{dibit + 2'd1, 1'b0} +: 2];
          end else if (underrun || fcs_done) begin
            state        <= IFG;
            ifg_cnt      <= 16'd0;
            dibit        <= 2'd0;
            eth_txen     <= 1'b0;
            eth_tx       <= 2'b00;
            err_underrun <= underrun;
          end else begin
            state   <= nxt_state;
            dibit   <= 2'd0;
            tx_byte <= nxt_byte;
            eth_tx  <= nxt_byte[1:0];
            if (state == PREAMBLE) pre_cnt <= pre_cnt + 3'd1;
            fcs_idx <= (state == FCS) ? fcs_nxt_idx : 2'd0;
            if (accept) last_byte <= s_last;
            if (crc_en) byte_cnt <= byte_cnt_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rmii_tx_mac.md
RMII_TX_MAC -- requirements
Module: rmii_tx_mac

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12, giving the inter-frame gap in byte times (4 clocks each).
REQ-002 SHALL have eth_clk  input  1  RMII 50 MHz reference clock; all logic on its rising edge.
REQ-003 SHALL have sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have s_valid  input  1  upstream byte valid.
REQ-005 SHALL have s_data  input  8  upstream payload byte (destination MAC first).
REQ-006 SHALL have s_last  input  1  marks the final payload byte of a frame.
REQ-007 SHALL have s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-008 SHALL have eth_txen  output  1  RMII TX_EN, registered.
REQ-009 SHALL have eth_tx  output  2  RMII TXD[1:0], registered.
REQ-010 SHALL have busy  output  1  high in every state except IDLE.
REQ-011 SHALL have err_underrun  output  1  one-cycle pulse on mid-frame underrun.

Function
REQ-012 SHALL use FSM states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-013 SHALL transmit one byte per 4 clocks, dibit counter 0..3, bits [1:0] first and [7:6] last.
REQ-014 IDLE: on s_valid=1, SHALL enter PREAMBLE without consuming the byte; eth_txen=1 with first dibit on the next cycle.
REQ-015 PREAMBLE SHALL send 7 bytes of 0x55; SFD SHALL send 1 byte of 0xD5.
REQ-016 s_ready SHALL be high only on dibit 3 of SFD or of a DATA byte not marked last; the byte accepted there is sent starting the next cycle.
REQ-017 If s_valid=0 when s_ready=1, SHALL drop eth_txen the next cycle, pulse err_underrun, skip FCS, and enter IFG.
REQ-018 After the s_last byte completes, SHALL go to PAD (REQ-026) or FCS.
REQ-019 CRC-32 SHALL run over payload and pad bytes: reflected poly 0xEDB88320, init 0xFFFFFFFF, one byte per accept.
REQ-020 FCS SHALL send the complemented CRC as 4 bytes, LSB byte first, then enter IFG.
REQ-021 IFG SHALL hold eth_txen=0 and eth_tx=00 for IFG_BYTES*4 clocks, then enter IDLE; s_valid SHALL be ignored during IFG.
REQ-022 eth_tx SHALL be 00 whenever eth_txen=0.
REQ-023 Frame and pad byte counter SHALL be 11 bits and saturate at 2047; frames longer than 2047 bytes SHALL be sent unmodified.

Reset
REQ-024 While sys_rst_n=0: state=IDLE, eth_txen=0, eth_tx=00, s_ready=0, busy=0, err_underrun=0, CRC=0xFFFFFFFF, counters=0.
REQ-025 Reset asserted mid-frame SHALL end eth_txen immediately; after release the block SHALL start in IDLE with no IFG.

Configuration
REQ-026 With RMII_TX_PAD_EN defined: payloads under 60 bytes SHALL be zero-padded to 60 bytes, with pad included in the CRC. Without it: no PAD state, and short frames SHALL be sent as-is.

Structure
REQ-027 Package eth_pkg SHALL hold the state enum, ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC_POLY, CRC_INIT and ETH_MIN_PAYLOAD=60.
REQ-028 The CRC SHALL be a sub-module crc32_d8: a byte-wide combinational next-state function with registered state, plus clear and enable inputs.

Verification
REQ-029 Payload "123456789" (9 bytes, pad macro off) -> 7x55, D5, payload, FCS 26 39 F4 CB; eth_txen high for exactly 21*4=84 clocks.
REQ-030 Back-to-back frames with s_valid held high -> exactly IFG_BYTES*4=48 clocks of eth_txen=0 between frames.
REQ-031 s_valid dropped when 3rd payload byte is due -> eth_txen falls the next cycle, one err_underrun pulse, no FCS, busy stays high for 48 clocks.
REQ-032 RMII_TX_PAD_EN, 14-byte payload -> 46 zero bytes appended, FCS matches the software CRC of 60 bytes, eth_txen high for 72*4 clocks.
REQ-033 sys_rst_n pulsed low during DATA -> eth_txen=0 asynchronously; next s_valid starts a full preamble 1 cycle after sampling.
REQ-034 Dibit order check: byte 0xA5 -> dibits 01, 01, 10, 10 on consecutive clocks.
